// File: rtl/cache_control_pkg.sv
// rtl/cache_control_pkg.sv - shared control address map and event bundle for cache_control
package cache_control_pkg;

  localparam int CTRL_ADDR_W = 4;

  // Values are shared with software drivers; keep them stable.
  typedef enum logic [CTRL_ADDR_W-1:0] {
    ADDR_NONE       = 4'd0,
    ADDR_WTB_EMPTY  = 4'd1,
    ADDR_WTB_FULL   = 4'd2,
    ADDR_RW_HIT     = 4'd3,
    ADDR_RW_MISS    = 4'd4,
    ADDR_READ_HIT   = 4'd5,
    ADDR_READ_MISS  = 4'd6,
    ADDR_WRITE_HIT  = 4'd7,
    ADDR_WRITE_MISS = 4'd8,
    ADDR_RST_CNT    = 4'd9,
    ADDR_INVALIDATE = 4'd10
  } ctrl_addr_e;

  typedef struct packed {
    logic write_miss;
    logic write_hit;
    logic read_miss;
    logic read_hit;
  } cache_evt_t;

endpackage

// File: rtl/cache_control_if.sv
// rtl/cache_control_if.sv - control request/response bus between cache front-end and cache_control
interface cache_control_if #(
  parameter int DATA_W = 32
);
  import cache_control_pkg::*;

  logic                   valid;
  logic [CTRL_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]      rdata;
  logic                   ready;

  modport master (output valid, addr, input rdata, ready);
  modport slave  (input valid, addr, output rdata, ready);

endinterface

// File: rtl/cache_ctrl_counters.sv
// rtl/cache_ctrl_counters.sv - hit/miss performance counters with synchronous clear
module cache_ctrl_counters
  import cache_control_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  cache_evt_t        i_evt,
  output logic [DATA_W-1:0] o_read_hit,
  output logic [DATA_W-1:0] o_read_miss,
  output logic [DATA_W-1:0] o_write_hit,
  output logic [DATA_W-1:0] o_write_miss,
  output logic [DATA_W-1:0] o_rw_hit,
  output logic [DATA_W-1:0] o_rw_miss
);

  logic [DATA_W-1:0] r_hit_rd;
  logic [DATA_W-1:0] r_miss_rd;
  logic [DATA_W-1:0] r_hit_wr;
  logic [DATA_W-1:0] r_miss_wr;

  // Clear dominates any event landing in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_hit_rd  <= '0;
      r_miss_rd <= '0;
      r_hit_wr  <= '0;
      r_miss_wr <= '0;
    end else begin
      if (i_evt.read_hit)   r_hit_rd  <= r_hit_rd + 1'b1;
      if (i_evt.read_miss)  r_miss_rd <= r_miss_rd + 1'b1;
      if (i_evt.write_hit)  r_hit_wr  <= r_hit_wr + 1'b1;
      if (i_evt.write_miss) r_miss_wr <= r_miss_wr + 1'b1;
    end
  end

  assign o_read_hit   = r_hit_rd;
  assign o_read_miss  = r_miss_rd;
  assign o_write_hit  = r_hit_wr;
  assign o_write_miss = r_miss_wr;
  assign o_rw_hit     = r_hit_rd + r_hit_wr;
  assign o_rw_miss    = r_miss_rd + r_miss_wr;

endmodule

// File: rtl/cache_control.sv
// rtl/cache_control.sv - cache control/status slave: registered reads, counter clear, invalidate pulse
module cache_control
  import cache_control_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CTRL_CNT = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  cache_control_if.slave   bus,
  input  logic             i_wtbuf_empty,
  input  logic             i_wtbuf_full,
  input  logic             i_write_hit,
  input  logic             i_write_miss,
  input  logic             i_read_hit,
  input  logic             i_read_miss,
  output logic             o_invalidate
);

  logic              r_ready;
  logic              r_invalidate;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_rdata_next;
  logic              w_clear;
  logic [DATA_W-1:0] w_read_hit, w_read_miss, w_write_hit, w_write_miss;
  logic [DATA_W-1:0] w_rw_hit, w_rw_miss;
  cache_evt_t        w_evt;

  assign w_evt   = '{write_miss: i_write_miss, write_hit: i_write_hit,
                     read_miss: i_read_miss, read_hit: i_read_hit};
  assign w_clear = bus.valid && (bus.addr == ADDR_RST_CNT);

  generate
    if (CTRL_CNT != 0) begin : g_cnt
      cache_ctrl_counters #(.DATA_W(DATA_W)) u_counters (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_clear),
        .i_evt        (w_evt),
        .o_read_hit   (w_read_hit),
        .o_read_miss  (w_read_miss),
        .o_write_hit  (w_write_hit),
        .o_write_miss (w_write_miss),
        .o_rw_hit     (w_rw_hit),
        .o_rw_miss    (w_rw_miss)
      );
    end else begin : g_no_cnt
      assign w_read_hit   = '0;
      assign w_read_miss  = '0;
      assign w_write_hit  = '0;
      assign w_write_miss = '0;
      assign w_rw_hit     = '0;
      assign w_rw_miss    = '0;
    end
  endgenerate

  // Mux reads the counters in the request cycle, so same-cycle events are not yet visible.
  always_comb begin
    w_rdata_next = '0;
    case (bus.addr)
      ADDR_WTB_EMPTY:  w_rdata_next = DATA_W'(i_wtbuf_empty);
      ADDR_WTB_FULL:   w_rdata_next = DATA_W'(i_wtbuf_full);
      ADDR_RW_HIT:     w_rdata_next = w_rw_hit;
      ADDR_RW_MISS:    w_rdata_next = w_rw_miss;
      ADDR_READ_HIT:   w_rdata_next = w_read_hit;
      ADDR_READ_MISS:  w_rdata_next = w_read_miss;
      ADDR_WRITE_HIT:  w_rdata_next = w_write_hit;
      ADDR_WRITE_MISS: w_rdata_next = w_write_miss;
      default:         w_rdata_next = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ready      <= 1'b0;
      r_invalidate <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_ready      <= bus.valid;
      r_invalidate <= bus.valid && (bus.addr == ADDR_INVALIDATE);
      if (bus.valid) r_rdata <= w_rdata_next;
    end
  end

  assign bus.ready    = r_ready;
  assign bus.rdata    = r_rdata;
  assign o_invalidate = r_invalidate;

endmodule
